bsg_gateway_wh_mem_responder: RTL and testbench

//  Multi-channel, nonsynth wormhole memory model for gateway-chip testbenches.

---
 rtl/bsg_gateway_wh_mem_responder.sv | 194 +++++++++++++++++++
 tb/tb_bsg_gateway_wh_mem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_gateway_wh_mem_responder.sv
// Multi-channel wormhole memory responder: each channel owns a private bank and answers
// read/write block requests. Define BSG_WH_MEM_RESPONDER_TRACE_EN for reply trace and header checks.
module bsg_gateway_wh_mem_responder #(
    parameter int flit_width_p  = 32,
    parameter int cord_width_p  = 7,
    parameter int len_width_p   = 4,
    parameter int cid_width_p   = 5,
    parameter int channels_p    = 2,
    parameter int block_words_p = 8,
    parameter int mem_words_p   = 1024,
    parameter int latency_p     = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [channels_p-1:0]                v_i,
    input  logic [channels_p*flit_width_p-1:0]   data_i,
    output logic [channels_p-1:0]                ready_and_o,
    output logic [channels_p-1:0]                v_o,
    output logic [channels_p*flit_width_p-1:0]   data_o,
    input  logic [channels_p-1:0]                ready_and_i
);
    localparam int lg_mem_lp = (mem_words_p > 1) ? $clog2(mem_words_p) : 1;
    localparam int lat_w_lp  = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam int len_lsb_lp = cord_width_p;
    localparam int cid_lsb_lp = cord_width_p + len_width_p;
    localparam int wr_bit_lp  = cid_lsb_lp + cid_width_p;
    localparam int src_lsb_lp = wr_bit_lp + 1;

    typedef enum logic [2:0] {
        S_RX_HDR, S_RX_ADDR, S_RX_DATA, S_WAIT, S_TX_HDR, S_TX_DATA
    } state_e;

    function automatic logic [flit_width_p-1:0] reply_hdr(
        input logic [cord_width_p-1:0] dest,
        input logic [cord_width_p-1:0] src,
        input logic [cid_width_p-1:0]  cid,
        input logic                    wr
    );
        logic [flit_width_p-1:0] h;
        h = '0;
        h[cord_width_p-1:0]            = dest;
        h[len_lsb_lp +: len_width_p]   = wr ? '0 : len_width_p'(block_words_p);
        h[cid_lsb_lp +: cid_width_p]   = cid;
        h[wr_bit_lp]                   = wr;
        h[src_lsb_lp +: cord_width_p]  = src;
        return h;
    endfunction

    for (genvar c = 0; c < channels_p; c++) begin : g_ch
        state_e                    r_state;
        logic                      r_ready, r_v, r_write;
        logic [cord_width_p-1:0]   r_dest, r_src;
        logic [cid_width_p-1:0]    r_cid;
        logic [len_width_p-1:0]    r_rem, r_idx;
        logic [lg_mem_lp-1:0]      r_addr;
        logic [lat_w_lp-1:0]       r_wcnt;
        logic [flit_width_p-1:0]   r_data;
        logic [flit_width_p-1:0]   r_mem [mem_words_p];
        // Per-word written flag: clearing it on reset makes the whole bank read as zero.
        logic [mem_words_p-1:0]    r_valid;

        logic [flit_width_p-1:0]   w_din, w_rep_hdr, w_rd_word;
        logic [len_width_p-1:0]    w_hdr_len;
        logic [lg_mem_lp-1:0]      w_waddr, w_raddr;
        logic                      w_acc, w_deq, w_last_rx, w_mem_we, w_unused;

        assign w_din     = data_i[c*flit_width_p +: flit_width_p];
        assign w_unused  = ^w_din;
        assign w_acc     = v_i[c] & r_ready;
        assign w_deq     = r_v & ready_and_i[c];
        assign w_hdr_len = w_din[len_lsb_lp +: len_width_p];
        assign w_waddr   = r_addr + lg_mem_lp'(r_idx);
        assign w_raddr   = (r_state == S_TX_HDR) ? r_addr : w_waddr;
        assign w_rd_word = r_valid[w_raddr] ? r_mem[w_raddr] : '0;
        assign w_mem_we  = w_acc && (r_state == S_RX_DATA) && r_write;

        // Request length comes from the header; the write bit only chooses the reply shape.
        assign w_last_rx = w_acc && (((r_state == S_RX_HDR) && (w_hdr_len == '0)) ||
                                     ((r_state != S_RX_HDR) && (r_rem == len_width_p'(1))));
        assign w_rep_hdr = (r_state == S_RX_HDR)
            ? reply_hdr(w_din[src_lsb_lp +: cord_width_p], w_din[cord_width_p-1:0],
                        w_din[cid_lsb_lp +: cid_width_p], w_din[wr_bit_lp])
            : reply_hdr(r_src, r_dest, r_cid, r_write);

        always_ff @(posedge clk_i) begin
            if (w_mem_we) r_mem[w_waddr] <= w_din;
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_state <= S_RX_HDR;
                r_ready <= 1'b0;
                r_v     <= 1'b0;
                r_write <= 1'b0;
                r_dest  <= '0;
                r_src   <= '0;
                r_cid   <= '0;
                r_rem   <= '0;
                r_idx   <= '0;
                r_addr  <= '0;
                r_wcnt  <= '0;
                r_data  <= '0;
                r_valid <= '0;
            end else begin
                case (r_state)
                    S_RX_HDR: begin
                        r_ready <= 1'b1;
                        if (w_acc) begin
                            r_dest  <= w_din[cord_width_p-1:0];
                            r_src   <= w_din[src_lsb_lp +: cord_width_p];
                            r_cid   <= w_din[cid_lsb_lp +: cid_width_p];
                            r_write <= w_din[wr_bit_lp];
                            r_rem   <= w_hdr_len;
                            r_state <= S_RX_ADDR;
                        end
                    end
                    S_RX_ADDR: if (w_acc) begin
                        r_addr  <= w_din[lg_mem_lp-1:0];
                        r_idx   <= '0;
                        r_rem   <= r_rem - len_width_p'(1);
                        r_state <= S_RX_DATA;
                    end
                    S_RX_DATA: if (w_acc) begin
                        if (r_write) r_valid[w_waddr] <= 1'b1;
                        r_idx <= r_idx + len_width_p'(1);
                        r_rem <= r_rem - len_width_p'(1);
                    end
                    S_WAIT: begin
                        if (r_wcnt == lat_w_lp'(latency_p - 1)) begin
                            r_state <= S_TX_HDR;
                            r_v     <= 1'b1;
                            r_data  <= w_rep_hdr;
                        end else begin
                            r_wcnt <= r_wcnt + lat_w_lp'(1);
                        end
                    end
                    S_TX_HDR: if (w_deq) begin
                        if (r_write) begin
                            r_state <= S_RX_HDR;
                            r_v     <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_TX_DATA;
                            r_data  <= w_rd_word;
                            r_idx   <= len_width_p'(1);
                        end
                    end
                    S_TX_DATA: if (w_deq) begin
                        if (r_idx == len_width_p'(block_words_p)) begin
                            r_state <= S_RX_HDR;
                            r_v     <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_data <= w_rd_word;
                            r_idx  <= r_idx + len_width_p'(1);
                        end
                    end
                    default: r_state <= S_RX_HDR;
                endcase
                if (w_last_rx) begin
                    r_ready <= 1'b0;
                    if (latency_p == 0) begin
                        r_state <= S_TX_HDR;
                        r_v     <= 1'b1;
                        r_data  <= w_rep_hdr;
                    end else begin
                        r_state <= S_WAIT;
                        r_wcnt  <= '0;
                    end
                end
            end
        end

        assign ready_and_o[c]                         = r_ready;
        assign v_o[c]                                 = r_v;
        assign data_o[c*flit_width_p +: flit_width_p] = r_data;

`ifdef BSG_WH_MEM_RESPONDER_TRACE_EN
        always @(posedge clk_i) begin
            if (reset_n_i) begin
                if (w_acc && (r_state == S_RX_HDR) &&
                    (w_hdr_len != (w_din[wr_bit_lp] ? len_width_p'(1 + block_words_p)
                                                    : len_width_p'(1))))
                    $error("ch%0d: header len %0d inconsistent with write=%0b",
                           c, w_hdr_len, w_din[wr_bit_lp]);
                if (w_deq && (((r_state == S_TX_HDR) && r_write) ||
                              ((r_state == S_TX_DATA) && (r_idx == len_width_p'(block_words_p)))))
                    $display("%0t ch%0d %s addr=%h cid=%h src_cord=%h",
                             $time, c, r_write ? "W" : "R", r_addr, r_cid, r_src);
            end
        end
`endif
    end
endmodule

// File: tb/tb_bsg_gateway_wh_mem_responder.sv
// Directed bench: a two-channel responder (latency 2) and a one-channel responder (latency 0),
// checked flit-by-flit against a queue/array model of memory and expected replies.
module tb_bsg_gateway_wh_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  v_i = '0;
    logic [95:0] data_i = '0;
    logic [2:0]  ready_and_i;
    logic [2:0]  ready_and_o, v_o;
    logic [95:0] data_o;
    logic [1:0]  ro01, vo01;
    logic [63:0] do01;
    logic        ro2, vo2;
    logic [31:0] do2;

    assign ready_and_o = {ro2, ro01};
    assign v_o         = {vo2, vo01};
    assign data_o      = {do2, do01};

    bsg_gateway_wh_mem_responder dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .v_i(v_i[1:0]), .data_i(data_i[63:0]), .ready_and_o(ro01),
        .v_o(vo01), .data_o(do01), .ready_and_i(ready_and_i[1:0])
    );

    bsg_gateway_wh_mem_responder #(.channels_p(1), .latency_p(0), .mem_words_p(64)) dut0 (
        .clk_i(clk), .reset_n_i(reset_n),
        .v_i(v_i[2]), .data_i(data_i[95:64]), .ready_and_o(ro2),
        .v_o(vo2), .data_o(do2), .ready_and_i(ready_and_i[2])
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0, cyc = 0;
    logic [31:0] mm [3][1024];
    int          mw [3] = '{1023, 1023, 63};
    logic [31:0] expq [3][$];
    logic [31:0] rep_log [3][$];
    int first_v_cyc[3], last_acc[3], last_out_cyc[3], hdr_acc[3], out_at_hdr[3], vrise_at_hdr[3];
    logic [31:0] first_v_dat[3], prev_dat[3];
    logic [2:0]  prev_stall = '0, prev_v = '0, bp = '0;
    logic [31:0] mon_d;

    initial forever begin @(posedge clk); cyc++; end

    initial begin
        ready_and_i = '1;
        forever begin
            @(posedge clk); #1;
            for (int l = 0; l < 3; l++)
                ready_and_i[l] = bp[l] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] hdr(int dest, int len, int cid, int w, int src);
        return 32'(dest) | (32'(len) << 7) | (32'(cid) << 11) | (32'(w) << 16) | (32'(src) << 17);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reply monitor: every consumed reply flit must be the next expected one.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = '0;
            prev_v     = '0;
        end else begin
            for (int l = 0; l < 3; l++) begin
                mon_d = data_o[l*32 +: 32];
                if (prev_stall[l]) begin
                    chk("stall_v", 32'(v_o[l]), 32'd1);
                    chk("stall_data", mon_d, prev_dat[l]);
                end
                if (v_o[l] && !prev_v[l]) begin
                    first_v_cyc[l] = cyc;
                    first_v_dat[l] = mon_d;
                end
                if (v_o[l] && ready_and_i[l]) begin
                    rep_log[l].push_back(mon_d);
                    last_out_cyc[l] = cyc;
                    if (expq[l].size() == 0) begin
                        nchk++; nerr++;
                        $display("FAIL unexpected_flit link %0d: got %h expected none", l, mon_d);
                    end else begin
                        chk("reply_flit", mon_d, expq[l].pop_front());
                    end
                end
                prev_stall[l] = v_o[l] & ~ready_and_i[l];
                prev_dat[l]   = mon_d;
                prev_v[l]     = v_o[l];
            end
        end
    end

    task automatic send_flit(int l, logic [31:0] f);
        int n = 0;
        v_i[l] = 1'b1;
        data_i[l*32 +: 32] = f;
        forever begin
            @(negedge clk);
            if (ready_and_o[l]) break;
            n++;
            if (n > 300) begin
                nchk++; nerr++;
                $display("FAIL accept_timeout link %0d: flit %h not accepted, expected accept", l, f);
                break;
            end
        end
        last_acc[l] = cyc;
        @(posedge clk); #1;
        v_i[l] = 1'b0;
    endtask

    task automatic send_req(int l, bit w, int addr, int len, int dbase, int cid);
        send_flit(l, hdr(5, len, cid, w, 3));
        hdr_acc[l] = last_acc[l];
        out_at_hdr[l] = last_out_cyc[l];
        vrise_at_hdr[l] = first_v_cyc[l];
        if (len >= 1) send_flit(l, 32'(addr));
        for (int k = 0; k < len - 1; k++) begin
            send_flit(l, 32'(dbase + k));
            if (w) mm[l][(addr + k) & mw[l]] = 32'(dbase + k);
        end
        if (w) expq[l].push_back(hdr(3, 0, cid, 1, 5));
        else begin
            expq[l].push_back(hdr(3, 8, cid, 0, 5));
            for (int k = 0; k < 8; k++) expq[l].push_back(mm[l][(addr + k) & mw[l]]);
        end
    endtask

    task automatic drain(int l);
        int n = 0;
        while (expq[l].size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (expq[l].size() != 0) begin
            nchk++; nerr++;
            $display("FAIL drain link %0d: %0d flits missing, expected 0", l, expq[l].size());
            expq[l].delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        v_i = '0;
        #1;
        chk("rst_v_o", 32'(v_o), 32'd0);
        chk("rst_ready", 32'(ready_and_o), 32'd0);
        chk("rst_data0", data_o[31:0], 32'd0);
        chk("rst_data1", data_o[63:32], 32'd0);
        chk("rst_data2", data_o[95:64], 32'd0);
        for (int l = 0; l < 3; l++) begin
            expq[l].delete();
            for (int i = 0; i < 1024; i++) mm[l][i] = '0;
        end
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        #1 chk("ready_before_edge", 32'(ready_and_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_edge", 32'(ready_and_o), 32'd7);
        @(posedge clk); #1;
    endtask

    int t;

    initial begin
        do_reset();

        // Write 1..8 at 0x10, ack three cycles after the last data flit, then read back.
        send_req(0, 1, 'h10, 9, 1, 9);
        t = last_acc[0];
        drain(0);
        chk("t1_ack_gap", 32'(first_v_cyc[0] - t), 32'd3);
        chk("t1_ack_hdr", first_v_dat[0], 32'h000B4803);
        rep_log[0].delete();
        send_req(0, 0, 'h10, 1, 0, 9);
        drain(0);
        chk("t1_rd_hdr", rep_log[0][0], 32'h000A4C03);
        chk("t1_rd_w0", rep_log[0][1], 32'd1);
        chk("t1_rd_w7", rep_log[0][8], 32'd8);

        // Block wrapping past the top of the bank.
        send_req(0, 1, 1021, 9, 1, 9);
        drain(0);
        rep_log[0].delete();
        send_req(0, 0, 0, 1, 0, 9);
        drain(0);
        chk("t2_w0", rep_log[0][1], 32'd4);
        chk("t2_w4", rep_log[0][5], 32'd8);
        chk("t2_w5", rep_log[0][6], 32'd0);

        // Both channels at once, same address, independent banks.
        fork
            send_req(0, 1, 'h20, 9, 'hA0, 1);
            send_req(1, 1, 'h20, 9, 'hB0, 2);
        join
        drain(0); drain(1);
        rep_log[0].delete(); rep_log[1].delete();
        fork
            send_req(0, 0, 'h20, 1, 0, 1);
            send_req(1, 0, 'h20, 1, 0, 2);
        join
        drain(0); drain(1);
        chk("t3_ch0", rep_log[0][1], 32'hA0);
        chk("t3_ch1", rep_log[1][8], 32'hB7);

        // Random reply backpressure.
        bp[0] = 1'b1;
        rep_log[0].delete();
        send_req(0, 0, 'h10, 1, 0, 3);
        drain(0);
        bp[0] = 1'b0;
        chk("t4_w3", rep_log[0][4], 32'd4);
        chk("t4_count", 32'(rep_log[0].size()), 32'd9);

        // Reset in the middle of a write packet.
        send_flit(0, hdr(5, 9, 9, 1, 3));
        send_flit(0, 32'h10);
        for (int k = 0; k < 3; k++) send_flit(0, 32'(100 + k));
        do_reset();
        rep_log[0].delete();
        send_req(0, 0, 'h10, 1, 0, 9);
        drain(0);
        chk("t5_w0", rep_log[0][1], 32'd0);
        chk("t5_w2", rep_log[0][3], 32'd0);

        // Zero latency, back-to-back reads.
        send_req(2, 1, 5, 9, 'h50, 1);
        drain(2);
        send_req(2, 0, 5, 1, 0, 2);
        t = last_acc[2];
        send_req(2, 0, 5, 1, 0, 3);
        chk("t6_hdr_gap", 32'(vrise_at_hdr[2] - t), 32'd1);
        chk("t6_next_hdr", 32'(hdr_acc[2] - out_at_hdr[2]), 32'd1);
        drain(2);

        // Headers whose len disagrees with the write bit.
        send_req(2, 0, 7, 3, 'h99, 4);
        drain(2);
        send_req(2, 1, 7, 1, 0, 5);
        drain(2);
        chk("t7_ack_hdr", first_v_dat[2], 32'h000B2803);
        rep_log[2].delete();
        send_req(2, 0, 7, 1, 0, 6);
        drain(2);
        chk("t7_w0", rep_log[2][1], 32'h52);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
